// File: rtl/dataflow_demux.sv
// dataflow_demux: 1-to-2 valid/ready demux buffered by a main register plus a skid register.
// One-cycle latency. i_ready is registered; a stalled head word blocks later words for both outputs.
module dataflow_demux #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [width-1:0] i_data,
   input  logic             select,
   output logic [1:0]       o_valid,
   input  logic [1:0]       o_ready,
   output logic [width-1:0] o_data_0,
   output logic [width-1:0] o_data_1
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic             r_i_ready;
   logic             r_main_dest;
   logic             r_skid_dest;
   logic [width-1:0] r_main_data;
   logic [width-1:0] r_skid_data;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_load_main_in;
   logic             w_load_main_skid;
   logic             w_load_skid;

   assign w_in_xfer  = i_valid && r_i_ready;
   assign w_out_xfer = |(o_valid & o_ready);

   always_comb begin
      w_next_state     = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_in_xfer) begin
               w_load_main_in = 1'b1;
               w_next_state   = BUSY;
            end
         end
         BUSY: begin
            if (w_in_xfer && w_out_xfer) begin
               w_load_main_in = 1'b1;
            end else if (w_in_xfer) begin
               w_load_skid  = 1'b1;
               w_next_state = FULL;
            end else if (w_out_xfer) begin
               w_next_state = EMPTY;
            end
         end
         FULL: begin
            if (w_out_xfer) begin
               w_load_main_skid = 1'b1;
               w_next_state     = BUSY;
            end
         end
         default: w_next_state = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= EMPTY;
         r_i_ready   <= 1'b0;
         r_main_dest <= 1'b0;
         r_main_data <= '0;
         r_skid_dest <= 1'b0;
         r_skid_data <= '0;
      end else begin
         r_state   <= w_next_state;
         // Registered from the next state so i_ready never depends combinationally on o_ready.
         r_i_ready <= (w_next_state != FULL);
         if (w_load_main_in) begin
            r_main_dest <= select;
            r_main_data <= i_data;
         end else if (w_load_main_skid) begin
            r_main_dest <= r_skid_dest;
            r_main_data <= r_skid_data;
         end
         if (w_load_skid) begin
            r_skid_dest <= select;
            r_skid_data <= i_data;
         end
      end
   end

   assign i_ready  = r_i_ready;
   assign o_valid  = (r_state != EMPTY) ? (r_main_dest ? 2'b10 : 2'b01) : 2'b00;
   assign o_data_0 = r_main_data;
   assign o_data_1 = r_main_data;

endmodule

// File: tb/tb_dataflow_demux.sv
// Bench for dataflow_demux: directed scenarios plus a random phase, all outputs checked against a scoreboard.
module tb_dataflow_demux;

   logic       clk;
   logic       reset;
   logic       i_valid;
   logic       i_ready;
   logic [7:0] i_data;
   logic       select;
   logic [1:0] o_valid;
   logic [1:0] o_ready;
   logic [7:0] o_data_0;
   logic [7:0] o_data_1;

   typedef struct packed {
      logic       dest;
      logic [7:0] data;
   } ent_t;

   ent_t sb[$];
   int   total = 0;
   int   bad   = 0;

   logic       prev_stall = 1'b0;
   logic [1:0] prev_vld   = 2'b00;
   logic [7:0] prev_dat   = 8'h00;

   dataflow_demux #(.width(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .i_data   (i_data),
      .select   (select),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .o_data_0 (o_data_0),
      .o_data_1 (o_data_1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus just after the rising edge, return at the falling edge for sampling.
   task automatic cyc(input logic v, input logic [7:0] d, input logic s, input logic [1:0] r);
      @(posedge clk);
      #1;
      i_valid = v;
      i_data  = d;
      select  = s;
      o_ready = r;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         ent_t e;
         check("onehot", 32'(o_valid == 2'b11), 32'd0);
         if (prev_stall) begin
            check("hold_vld", 32'(o_valid), 32'(prev_vld));
            check("hold_dat", 32'(o_data_0), 32'(prev_dat));
         end
         for (int d = 0; d < 2; d++) begin
            if (o_valid[d] && o_ready[d]) begin
               if (sb.size() == 0) begin
                  check("extra_out", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("sb_dest", 32'(d), 32'(e.dest));
                  check("sb_data", 32'((d == 1) ? o_data_1 : o_data_0), 32'(e.data));
               end
            end
         end
         if (i_valid && i_ready) sb.push_back({select, i_data});
         prev_stall = |(o_valid & ~o_ready);
         prev_vld   = o_valid;
         prev_dat   = o_data_0;
      end
   end

   initial begin
      reset   = 1'b1;
      i_valid = 1'b0;
      i_data  = 8'h00;
      select  = 1'b0;
      o_ready = 2'b00;
      #12;
      check("rst_vld", 32'(o_valid), 32'd0);
      check("rst_rdy", 32'(i_ready), 32'd0);
      check("rst_dat", 32'(o_data_0), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rel_rdy", 32'(i_ready), 32'd1);
      check("rel_vld", 32'(o_valid), 32'd0);

      // Streaming at full rate
      cyc(1'b1, 8'h11, 1'b0, 2'b11);
      check("st0_rdy", 32'(i_ready), 32'd1);
      check("st0_vld", 32'(o_valid), 32'd0);
      cyc(1'b1, 8'h22, 1'b1, 2'b11);
      check("st1_vld", 32'(o_valid), 32'h1);
      check("st1_dat", 32'(o_data_0), 32'h11);
      check("st1_rdy", 32'(i_ready), 32'd1);
      cyc(1'b1, 8'h33, 1'b0, 2'b11);
      check("st2_vld", 32'(o_valid), 32'h2);
      check("st2_dat", 32'(o_data_1), 32'h22);
      check("st2_rdy", 32'(i_ready), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 2'b11);
      check("st3_vld", 32'(o_valid), 32'h1);
      check("st3_dat", 32'(o_data_0), 32'h33);
      cyc(1'b0, 8'h00, 1'b0, 2'b11);
      check("st4_vld", 32'(o_valid), 32'h0);

      // Backpressure: A, B fill the buffer, C waits
      cyc(1'b1, 8'hA5, 1'b0, 2'b00);
      check("bp_a_rdy", 32'(i_ready), 32'd1);
      cyc(1'b1, 8'h5A, 1'b1, 2'b00);
      check("bp_b_vld", 32'(o_valid), 32'h1);
      check("bp_b_rdy", 32'(i_ready), 32'd1);
      cyc(1'b1, 8'hC3, 1'b0, 2'b00);
      check("bp_full_rdy", 32'(i_ready), 32'd0);
      check("bp_full_vld", 32'(o_valid), 32'h1);
      cyc(1'b1, 8'hC3, 1'b0, 2'b01);
      check("bp_pop_rdy", 32'(i_ready), 32'd0);
      check("bp_pop_dat", 32'(o_data_0), 32'hA5);
      cyc(1'b1, 8'hC3, 1'b0, 2'b00);
      check("bp_b_out_vld", 32'(o_valid), 32'h2);
      check("bp_b_out_dat", 32'(o_data_1), 32'h5A);
      check("bp_b_out_rdy", 32'(i_ready), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 2'b00);
      check("bp_c_in_rdy", 32'(i_ready), 32'd0);
      check("bp_c_in_vld", 32'(o_valid), 32'h2);
      cyc(1'b0, 8'h00, 1'b0, 2'b11);
      cyc(1'b0, 8'h00, 1'b0, 2'b11);
      check("bp_c_vld", 32'(o_valid), 32'h1);
      check("bp_c_dat", 32'(o_data_0), 32'hC3);
      cyc(1'b0, 8'h00, 1'b0, 2'b11);
      check("bp_end_vld", 32'(o_valid), 32'h0);
      check("bp_end_rdy", 32'(i_ready), 32'd1);

      // Head-of-line blocking
      cyc(1'b1, 8'h01, 1'b1, 2'b01);
      cyc(1'b1, 8'h02, 1'b0, 2'b01);
      check("hol0_vld", 32'(o_valid), 32'h2);
      check("hol0_dat", 32'(o_data_1), 32'h01);
      cyc(1'b0, 8'h00, 1'b0, 2'b01);
      check("hol1_vld", 32'(o_valid), 32'h2);
      check("hol1_rdy", 32'(i_ready), 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 2'b01);
      check("hol2_vld", 32'(o_valid), 32'h2);
      cyc(1'b0, 8'h00, 1'b0, 2'b10);
      check("hol3_dat", 32'(o_data_1), 32'h01);
      cyc(1'b0, 8'h00, 1'b0, 2'b01);
      check("hol4_vld", 32'(o_valid), 32'h1);
      check("hol4_dat", 32'(o_data_0), 32'h02);
      cyc(1'b0, 8'h00, 1'b0, 2'b00);
      check("hol5_vld", 32'(o_valid), 32'h0);

      // Select toggling while full; only the accepting edge's value counts
      cyc(1'b1, 8'h40, 1'b0, 2'b00);
      cyc(1'b1, 8'h41, 1'b1, 2'b00);
      cyc(1'b1, 8'h77, 1'b0, 2'b00);
      check("ls_full0", 32'(i_ready), 32'd0);
      cyc(1'b1, 8'h77, 1'b1, 2'b00);
      check("ls_full1", 32'(i_ready), 32'd0);
      cyc(1'b1, 8'h77, 1'b0, 2'b01);
      check("ls_full2", 32'(i_ready), 32'd0);
      cyc(1'b1, 8'h77, 1'b1, 2'b00);
      check("ls_free_rdy", 32'(i_ready), 32'd1);
      check("ls_free_vld", 32'(o_valid), 32'h2);
      cyc(1'b0, 8'h00, 1'b0, 2'b00);
      check("ls_refull", 32'(i_ready), 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 2'b11);
      cyc(1'b0, 8'h00, 1'b0, 2'b11);
      check("ls_route_vld", 32'(o_valid), 32'h2);
      check("ls_route_dat", 32'(o_data_1), 32'h77);
      cyc(1'b0, 8'h00, 1'b0, 2'b11);
      check("ls_end_vld", 32'(o_valid), 32'h0);

      // Reset while FULL, asserted between edges
      cyc(1'b1, 8'h90, 1'b0, 2'b00);
      cyc(1'b1, 8'h91, 1'b1, 2'b00);
      cyc(1'b0, 8'h00, 1'b0, 2'b00);
      check("mr_full", 32'(i_ready), 32'd0);
      #2;
      reset = 1'b1;
      sb.delete();
      #1;
      check("mr_vld", 32'(o_valid), 32'd0);
      check("mr_rdy", 32'(i_ready), 32'd0);
      check("mr_dat", 32'(o_data_1), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mr_pre_rdy", 32'(i_ready), 32'd0);
      @(posedge clk);
      #1;
      check("mr_rel_rdy", 32'(i_ready), 32'd1);
      check("mr_rel_vld", 32'(o_valid), 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 2'b11);
      check("mr_after_vld", 32'(o_valid), 32'd0);

      // Random traffic, then drain
      for (int k = 0; k < 400; k++) begin
         cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
      for (int k = 0; k < 6; k++) cyc(1'b0, 8'h00, 1'b0, 2'b11);
      check("drain_empty", 32'(sb.size()), 32'd0);
      check("drain_vld", 32'(o_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
